// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, exception types, ExcCodes, reset values.
// CP0_BADVADDR_EN adds the address-error exception types (AdEL/AdES).
package cp0_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [ADDR_W-1:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [ADDR_W-1:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [ADDR_W-1:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_REG_EPC      = 5'd14;
  localparam logic [ADDR_W-1:0] CP0_REG_PRID     = 5'd15;
  localparam logic [ADDR_W-1:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [DATA_W-1:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [DATA_W-1:0] EXC_ADEL      = 32'h0000_0004;
  localparam logic [DATA_W-1:0] EXC_ADES      = 32'h0000_0005;
  localparam logic [DATA_W-1:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [DATA_W-1:0] EXC_RI        = 32'h0000_000a;
  localparam logic [DATA_W-1:0] EXC_OV        = 32'h0000_000c;
  localparam logic [DATA_W-1:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [DATA_W-1:0] EXC_ERET      = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;

  localparam logic [DATA_W-1:0] STATUS_RESET = 32'h1000_0000;
  localparam logic [DATA_W-1:0] CONFIG_RESET = 32'h0000_8000;
  localparam logic [DATA_W-1:0] CAUSE_WMASK  = 32'h00C0_0300;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned CAUSE_BD   = 31;

  typedef struct packed {
    logic       valid;
    logic       eret;
    logic [4:0] exccode;
  } exc_dec_t;

  // Map an exception type from MEM to an action; unknown types decode to no action.
  function automatic exc_dec_t decode_exc(input logic [DATA_W-1:0] t);
    exc_dec_t d;
    d       = '0;
    d.valid = 1'b1;
    case (t)
      EXC_INTERRUPT: d.exccode = EXCCODE_INT;
      EXC_SYSCALL:   d.exccode = EXCCODE_SYS;
      EXC_RI:        d.exccode = EXCCODE_RI;
      EXC_OV:        d.exccode = EXCCODE_OV;
      EXC_TRAP:      d.exccode = EXCCODE_TR;
`ifdef CP0_BADVADDR_EN
      EXC_ADEL:      d.exccode = EXCCODE_ADEL;
      EXC_ADES:      d.exccode = EXCCODE_ADES;
`endif
      EXC_ERET: begin
        d.valid = 1'b0;
        d.eret  = 1'b1;
      end
      default:       d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] cause_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] wr);
    return (cur & ~CAUSE_WMASK) | (wr & CAUSE_WMASK);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and the timer interrupt latch.
// Independent of CP0_BADVADDR_EN.
module cp0_timer
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_count_i,
  input  logic              we_compare_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] compare_o,
  output logic              timer_int_o
);

  localparam int unsigned PRE_W = 8;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(COUNT_DIV - 1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic              timer_q, timer_d;
  logic              tick;

  // A Compare write clears the latch and overrides a same-cycle match.
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    timer_d   = timer_q;
    tick      = 1'b0;
    if (we_count_i) begin
      count_d = wdata_i;
      presc_d = '0;
    end else if (presc_q == PRE_MAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
      tick    = 1'b1;
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
    if (we_compare_i) begin
      compare_d = wdata_i;
      timer_d   = 1'b0;
    end else if (tick && (count_d == compare_q) && (compare_q != '0)) begin
      timer_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/Config/PrId, exception entry/return and read port.
// Define CP0_BADVADDR_EN to add BadVAddr and the AdEL/AdES exception types.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned       NUM_HW_INT     = 6,
  parameter int unsigned       TIMER_IRQ_LINE = 5,
  parameter int unsigned       COUNT_DIV      = 1,
  parameter logic [DATA_W-1:0] PRID_VALUE     = 32'h1088_0102
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     data_o,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic [DATA_W-1:0]     excepttype_i,
  input  logic [DATA_W-1:0]     current_inst_addr_i,
  input  logic                  is_in_delayslot_i,
`ifdef CP0_BADVADDR_EN
  input  logic [DATA_W-1:0]     bad_addr_i,
`endif
  output logic [DATA_W-1:0]     count_o,
  output logic [DATA_W-1:0]     compare_o,
  output logic [DATA_W-1:0]     status_o,
  output logic [DATA_W-1:0]     cause_o,
  output logic [DATA_W-1:0]     epc_o,
  output logic [DATA_W-1:0]     config_o,
  output logic                  timer_int_o,
  output logic                  int_pending_o
);

  logic [DATA_W-1:0] status_q, status_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [5:0]        hw_ip;
  logic [DATA_W-1:0] rdata;
  exc_dec_t          exc;
`ifdef CP0_BADVADDR_EN
  logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
`endif

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .we_count_i   (we_i && (waddr_i == CP0_REG_COUNT)),
    .we_compare_i (we_i && (waddr_i == CP0_REG_COMPARE)),
    .wdata_i      (data_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .timer_int_o  (timer_int_o)
  );

  assign exc = decode_exc(excepttype_i);

  always_comb begin
    hw_ip                 = 6'(int_i);
    hw_ip[TIMER_IRQ_LINE] = hw_ip[TIMER_IRQ_LINE] | timer_int_o;
  end

  // mtc0 first, then the exception/eret update so it wins on shared fields.
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (we_i) begin
      case (waddr_i)
        CP0_REG_STATUS: status_d = data_i;
        CP0_REG_CAUSE:  cause_d  = cause_merge(cause_q, data_i);
        CP0_REG_EPC:    epc_d    = data_i;
        default: ;
      endcase
    end
    cause_d[15:10] = hw_ip;
    if (exc.valid) begin
      if (!status_q[STATUS_EXL]) begin
        epc_d             = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
        cause_d[CAUSE_BD] = is_in_delayslot_i;
      end
      status_d[STATUS_EXL] = 1'b1;
      cause_d[6:2]         = exc.exccode;
    end else if (exc.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

`ifdef CP0_BADVADDR_EN
  always_comb begin
    badvaddr_d = badvaddr_q;
    if (exc.valid && ((exc.exccode == EXCCODE_ADEL) || (exc.exccode == EXCCODE_ADES))) begin
      badvaddr_d = bad_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) badvaddr_q <= '0;
    else      badvaddr_q <= badvaddr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  // Read mux with write-through bypass for the writable registers.
  always_comb begin
    rdata = '0;
    case (raddr_i)
      CP0_REG_COUNT:    rdata = count_o;
      CP0_REG_COMPARE:  rdata = compare_o;
      CP0_REG_STATUS:   rdata = status_q;
      CP0_REG_CAUSE:    rdata = cause_q;
      CP0_REG_EPC:      rdata = epc_q;
      CP0_REG_PRID:     rdata = PRID_VALUE;
      CP0_REG_CONFIG:   rdata = CONFIG_RESET;
`ifdef CP0_BADVADDR_EN
      CP0_REG_BADVADDR: rdata = badvaddr_q;
`endif
      default: ;
    endcase
    if (we_i && (waddr_i == raddr_i)) begin
      case (waddr_i)
        CP0_REG_COUNT, CP0_REG_COMPARE, CP0_REG_STATUS, CP0_REG_EPC: rdata = data_i;
        CP0_REG_CAUSE: rdata = cause_merge(cause_q, data_i);
        default: ;
      endcase
    end
    if (!rst) rdata = '0;
  end

  assign data_o        = rdata;
  assign status_o      = status_q;
  assign cause_o       = cause_q;
  assign epc_o         = epc_q;
  assign config_o      = CONFIG_RESET;
  assign int_pending_o = rst & status_q[STATUS_IE] & ~status_q[STATUS_EXL]
                         & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios plus random traffic against a behavioural CP0 model.
module tb_cp0_regfile;

  localparam int unsigned NHW  = 6;
  localparam int unsigned DIV  = 4;
  localparam logic [31:0] PRID = 32'h1088_0102;
  localparam logic [31:0] WMSK = 32'h00C0_0300;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic [4:0]     raddr = '0;
  logic [4:0]     waddr = '0;
  logic           we    = 1'b0;
  logic [31:0]    wdata = '0;
  logic [31:0]    etype = '0;
  logic [31:0]    pc    = '0;
  logic [31:0]    badaddr = '0;
  logic [NHW-1:0] irq   = '0;
  logic           ds    = 1'b0;

  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o;
  logic        timer_int_o, int_pending_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cp0_regfile #(
    .NUM_HW_INT     (NHW),
    .TIMER_IRQ_LINE (5),
    .COUNT_DIV      (DIV),
    .PRID_VALUE     (PRID)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .raddr_i             (raddr),
    .data_o              (data_o),
    .we_i                (we),
    .waddr_i             (waddr),
    .data_i              (wdata),
    .int_i               (irq),
    .excepttype_i        (etype),
    .current_inst_addr_i (pc),
    .is_in_delayslot_i   (ds),
`ifdef CP0_BADVADDR_EN
    .bad_addr_i          (badaddr),
`endif
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .config_o            (config_o),
    .timer_int_o         (timer_int_o),
    .int_pending_o       (int_pending_o)
  );

  // Architectural state of the reference model
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc, m_badv;
  int          m_tick;
  bit          m_timer;

  // ExcCode for an exception type, -1 for no exception
  function automatic int exc_code(input logic [31:0] t);
    case (t)
      32'h1: return 0;
      32'h8: return 8;
      32'ha: return 10;
      32'hc: return 12;
      32'hd: return 13;
`ifdef CP0_BADVADDR_EN
      32'h4: return 4;
      32'h5: return 5;
`endif
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int          ec;
    bit          inc;
    logic [31:0] c, cmp, st, ca, ep;
    bit          tm;
    int          tk;
    if (!rst) begin
      m_count = 0; m_compare = 0; m_status = 32'h1000_0000; m_cause = 0;
      m_epc = 0; m_badv = 0; m_tick = 0; m_timer = 0;
    end else begin
      ec  = exc_code(etype);
      inc = 0;
      c   = m_count;
      tk  = m_tick;
      if (we && waddr == 5'd9) begin
        c = wdata; tk = 0;
      end else if (m_tick == DIV - 1) begin
        c = m_count + 32'd1; tk = 0; inc = 1;
      end else begin
        tk = m_tick + 1;
      end
      cmp = (we && waddr == 5'd11) ? wdata : m_compare;
      if (we && waddr == 5'd11)                             tm = 0;
      else if (inc && c == m_compare && m_compare != 0)     tm = 1;
      else                                                  tm = m_timer;
      st = (we && waddr == 5'd12) ? wdata : m_status;
      ep = (we && waddr == 5'd14) ? wdata : m_epc;
      ca = (we && waddr == 5'd13) ? ((m_cause & ~WMSK) | (wdata & WMSK)) : m_cause;
      ca[15:10] = 6'(irq) | (6'(m_timer) << 5);
      if (ec >= 0) begin
        if (!m_status[1]) begin
          ep = ds ? pc - 32'd4 : pc;
          ca[31] = ds;
        end
        st[1] = 1'b1;
        ca[6:2] = 5'(ec);
        if (ec == 4 || ec == 5) m_badv = badaddr;
      end else if (etype == 32'he) begin
        st[1] = 1'b0;
      end
      m_count = c; m_tick = tk; m_compare = cmp; m_timer = tm;
      m_status = st; m_cause = ca; m_epc = ep;
    end
  end

  function automatic logic [31:0] exp_read();
    logic [31:0] v;
    if (!rst) return 32'h0;
    case (raddr)
      5'd9:  v = m_count;
      5'd11: v = m_compare;
      5'd12: v = m_status;
      5'd13: v = m_cause;
      5'd14: v = m_epc;
      5'd15: v = PRID;
      5'd16: v = 32'h0000_8000;
`ifdef CP0_BADVADDR_EN
      5'd8:  v = m_badv;
`endif
      default: v = 32'h0;
    endcase
    if (we && waddr == raddr) begin
      case (waddr)
        5'd9, 5'd11, 5'd12, 5'd14: v = wdata;
        5'd13: v = (m_cause & ~WMSK) | (wdata & WMSK);
        default: ;
      endcase
    end
    return v;
  endfunction

  function automatic logic exp_pending();
    return rst & m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("count_o",       count_o,                 m_count);
    check("compare_o",     compare_o,               m_compare);
    check("status_o",      status_o,                m_status);
    check("cause_o",       cause_o,                 m_cause);
    check("epc_o",         epc_o,                   m_epc);
    check("config_o",      config_o,                32'h0000_8000);
    check("timer_int_o",   32'(timer_int_o),        32'(m_timer));
    check("int_pending_o", 32'(int_pending_o),      32'(exp_pending()));
    check("data_o",        data_o,                  exp_read());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 8))
      0: return 5'd9;
      1: return 5'd11;
      2: return 5'd12;
      3: return 5'd13;
      4: return 5'd14;
      5: return 5'd15;
      6: return 5'd16;
      7: return 5'd8;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [31:0] pick_etype();
    case ($urandom_range(0, 9))
      0: return 32'h1;
      1: return 32'h8;
      2: return 32'ha;
      3: return 32'hc;
      4: return 32'hd;
      5: return 32'he;
      6: return 32'h4;
      7: return 32'h5;
      8: return 32'h2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2 rst = 1'b0;
    step();
    step();
    raddr = 5'd15;
    #1;
    check("reset prid read", data_o, 32'h0);
    check("reset status", status_o, 32'h1000_0000);
    check("reset config", config_o, 32'h0000_8000);
    check("reset pending", 32'(int_pending_o), 32'h0);

    // Timer: Compare=10, COUNT_DIV=4 -> match on edge 40 after release
    rst = 1'b1; we = 1'b1; waddr = 5'd11; wdata = 32'd10;
    step();
    we = 1'b0;
    repeat (38) step();
    check("count at edge 39", count_o, 32'd9);
    check("timer before match", 32'(timer_int_o), 32'h0);
    step();
    check("count at edge 40", count_o, 32'd10);
    check("timer at match", 32'(timer_int_o), 32'h1);
    we = 1'b1; waddr = 5'd11; wdata = 32'd0;
    step();
    we = 1'b0;
    check("timer cleared by compare write", 32'(timer_int_o), 32'h0);

    // Syscall in a delay slot with EXL=0
    etype = 32'h8; pc = 32'hBFC0_0100; ds = 1'b1;
    step();
    etype = 32'h0; ds = 1'b0;
    check("syscall epc", epc_o, 32'hBFC0_00FC);
    check("syscall bd", 32'(cause_o[31]), 32'h1);
    check("syscall exccode", 32'(cause_o[6:2]), 32'd8);
    check("syscall exl", 32'(status_o[1]), 32'h1);

    // Overflow while EXL=1, then eret
    etype = 32'hc; pc = 32'h8000_0000;
    step();
    etype = 32'h0;
    check("nested epc kept", epc_o, 32'hBFC0_00FC);
    check("nested exccode", 32'(cause_o[6:2]), 32'd12);
    etype = 32'he;
    step();
    etype = 32'h0;
    check("eret exl", 32'(status_o[1]), 32'h0);

    // Interrupt pending path
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0401;
    step();
    we = 1'b0;
    check("pending idle", 32'(int_pending_o), 32'h0);
    irq = 6'b000001;
    #1;
    check("pending same cycle", 32'(int_pending_o), 32'h0);
    step();
    check("pending after int", 32'(int_pending_o), 32'h1);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0403;
    step();
    we = 1'b0;
    check("pending masked by exl", 32'(int_pending_o), 32'h0);

    // Bypass read and exception-over-mtc0 priority
    we = 1'b1; waddr = 5'd14; wdata = 32'h0000_1234; raddr = 5'd14;
    #1;
    check("epc bypass", data_o, 32'h0000_1234);
    step();
    we = 1'b0;
    check("epc written", epc_o, 32'h0000_1234);
    we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0401;
    step();
    we = 1'b1; waddr = 5'd14; wdata = 32'h0000_5555;
    etype = 32'h8; pc = 32'h0000_0100; ds = 1'b0;
    step();
    we = 1'b0; etype = 32'h0;
    check("exception beats mtc0 epc", epc_o, 32'h0000_0100);

    // Random traffic
    repeat (3000) begin
      we    = ($urandom_range(0, 2) == 0);
      waddr = pick_addr();
      wdata = $urandom;
      if ((waddr == 5'd9 || waddr == 5'd11) && $urandom_range(0, 1) == 1)
        wdata = 32'($urandom_range(0, 40));
      raddr = ($urandom_range(0, 3) == 0) ? waddr : pick_addr();
      etype = ($urandom_range(0, 5) == 0) ? pick_etype() : 32'h0;
      pc    = $urandom;
      ds    = 1'($urandom);
      irq   = NHW'($urandom);
      badaddr = $urandom;
      step();
    end

    // Asynchronous reset mid-count
    we = 1'b1; waddr = 5'd9; wdata = 32'h77; etype = 32'h0; raddr = 5'd12;
    step();
    we = 1'b0;
    step();
    check("count before reset", count_o, 32'h77);
    #2 rst = 1'b0;
    #1;
    check("async reset count", count_o, 32'h0);
    check("async reset status", status_o, 32'h1000_0000);
    check("async reset data_o", data_o, 32'h0);
    check("async reset pending", 32'(int_pending_o), 32'h0);
    step();
    #2 rst = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameters SHALL be:
- NUM_HW_INT, 6, hardware interrupt lines (1..6)
- TIMER_IRQ_LINE, 5, hardware line index the timer is ORed into (< NUM_HW_INT)
- COUNT_DIV, 1, clk cycles per Count increment (1..256)
- PRID_VALUE, 32'h1088_0102, PrId read value
REQ-002 Ports, in this order:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- raddr_i  in  5  CP0 read address
- data_o  out  32  CP0 read data
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  write address
- data_i  in  32  write data
- int_i  in  NUM_HW_INT  hardware interrupt requests
- excepttype_i  in  32  exception code from MEM stage
- current_inst_addr_i  in  32  PC of excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot
- bad_addr_i  in  32  faulting address (CP0_BADVADDR_EN only)
- count_o, compare_o, status_o, cause_o, epc_o, config_o  out  32  register copies
- timer_int_o  out  1  timer interrupt latch
- int_pending_o  out  1  interrupt request to the pipeline

Function
REQ-003 Prescaler SHALL count 0..COUNT_DIV-1; Count SHALL increment when the prescaler wraps, with 32'hFFFF_FFFF wrapping to 0.
REQ-004 An mtc0 to Count SHALL load data_i and clear the prescaler; that cycle SHALL NOT increment.
REQ-005 timer_int_o SHALL set on the cycle Count increments to equal a nonzero Compare; it stays set until an mtc0 to Compare, which clears it and wins over a same-cycle match.
REQ-006 Cause[15:10] SHALL sample {int_i zero-extended to 6 bits} every cycle, with timer_int_o ORed into bit 10+TIMER_IRQ_LINE.
REQ-007 mtc0 SHALL write Status fully, EPC fully, and Cause bits 23, 22, 9:8 only; Config, PrId and unlisted addresses SHALL ignore writes.
REQ-008 Exception codes SHALL be: 0x1 interrupt (ExcCode 0), 0x8 syscall (8), 0xa reserved instruction (10), 0xc overflow (12), 0xd trap (13), 0xe eret; other values SHALL cause no action.
REQ-009 On an exception (not eret) with Status.EXL=0: EPC SHALL be current_inst_addr_i (minus 4 if in delay slot) and Cause.BD SHALL be is_in_delayslot_i. With EXL=1, EPC and BD SHALL be unchanged. In both cases EXL SHALL set and Cause[6:2] SHALL take the ExcCode.
REQ-010 eret SHALL clear Status.EXL.
REQ-011 An exception update SHALL take priority over a same-cycle mtc0 to the same field.
REQ-012 int_pending_o SHALL be Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational from the registers.
REQ-013 data_o SHALL be combinational. PrId SHALL return PRID_VALUE; undefined addresses SHALL return 0. When we_i=1 and waddr_i==raddr_i for a writable register, data_o SHALL return the post-write value (bypass).

Reset
REQ-014 While rst=0, registers SHALL take these values asynchronously:
- Count, Compare, Cause, EPC, prescaler, timer_int_o = 0
- Status = 32'h1000_0000
- Config = 32'h0000_8000
REQ-015 While rst=0, data_o SHALL be 0 and int_pending_o SHALL be 0. An exception or write in progress during reset SHALL be discarded.

Configuration
REQ-016 With CP0_BADVADDR_EN defined:
- BadVAddr (reg 8) SHALL exist and be read-only.
- Codes 0x4 (AdEL) and 0x5 (AdES) SHALL be accepted with ExcCode 4/5, following REQ-009, and SHALL load BadVAddr from bad_addr_i.
- BadVAddr SHALL reset to 0.
REQ-017 Without CP0_BADVADDR_EN, the bad_addr_i port SHALL be absent, reg 8 SHALL read 0, and codes 0x4/0x5 SHALL be ignored.

Structure
REQ-018 Register addresses (CP0_REG_*), exception-type codes, ExcCode values and reset constants SHALL live in the shared defines package.
REQ-019 The Count prescaler plus Compare match SHALL be one sub-module, cp0_timer, owning Count, Compare and timer_int_o.

Verification
REQ-020 The bench SHALL cover:
- COUNT_DIV=4, Compare=10 after reset: timer_int_o rises exactly at cycle 40 after Count increments to 10; mtc0 Compare=0 clears it the next edge.
- Status.EXL=0, syscall at PC 0xBFC0_0100 in delay slot: EPC=0xBFC0_00FC, Cause.BD=1, Cause[6:2]=8, EXL=1.
- A second overflow while EXL=1: EPC unchanged, Cause[6:2]=12; then eret: EXL=0.
- Status=0x0000_0401, int_i[0]=1: int_pending_o=1 one cycle after int_i asserts; with EXL set, int_pending_o=0.
- Same-cycle mtc0 EPC=0x1234 and raddr_i=EPC: data_o=0x1234 that cycle; same-cycle mtc0 EPC plus syscall: exception value wins.
- rst asserted mid-count: Count=0 and Status=0x1000_0000 immediately, without waiting for a clock edge.
